// File: rtl/cmn_state_pkg.sv
// ============================================================================
// Module      : cmn_state_pkg
// Description : Shared control-state encoding used by streaming stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmn_state_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage : cmn_state_pkg

`default_nettype wire

// File: rtl/complex_mac_pkg.sv
// ============================================================================
// Module      : complex_mac_pkg
// Description : Types, default sizes and helpers for the complex MAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package complex_mac_pkg;

    // Default sample width and frame depth
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int ACC_WIDTH = 2*WIDTH + $clog2(DEPTH) + 2;

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] re;
        logic signed [ACC_WIDTH-1:0] im;
    } acc_t;

    // Two's-complement add overflow: operands agree in sign, sum does not
    function automatic logic add_ovf(input logic a_msb,
                                     input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage : complex_mac_pkg

`default_nettype wire

// File: rtl/complex_mac_unit_cplx_mult.sv
// ============================================================================
// Module      : cplx_mult
// Description : Registered signed complex multiplier (first pipeline stage).
//               Products are 2*DATA_W+1 bits so the re/im sums never wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cplx_mult
    import complex_mac_pkg::*;
#(
    parameter int DATA_W = WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    input  logic signed [DATA_W-1:0]   i_a_re,
    input  logic signed [DATA_W-1:0]   i_a_im,
    input  logic signed [DATA_W-1:0]   i_b_re,
    input  logic signed [DATA_W-1:0]   i_b_im,
    output logic                       o_valid,
    output logic signed [2*DATA_W:0]   o_p_re,
    output logic signed [2*DATA_W:0]   o_p_im
);

    localparam int c_PROD_W = 2*DATA_W + 1;

    logic signed [c_PROD_W-1:0] w_rr;
    logic signed [c_PROD_W-1:0] w_ii;
    logic signed [c_PROD_W-1:0] w_ri;
    logic signed [c_PROD_W-1:0] w_ir;
    logic signed [c_PROD_W-1:0] r_p_re;
    logic signed [c_PROD_W-1:0] r_p_im;
    logic                       r_valid;

    assign w_rr = c_PROD_W'(i_a_re) * c_PROD_W'(i_b_re);
    assign w_ii = c_PROD_W'(i_a_im) * c_PROD_W'(i_b_im);
    assign w_ri = c_PROD_W'(i_a_re) * c_PROD_W'(i_b_im);
    assign w_ir = c_PROD_W'(i_a_im) * c_PROD_W'(i_b_re);

    // Capture the complex product on each accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_p_re  <= '0;
            r_p_im  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_p_re <= w_rr - w_ii;
                r_p_im <= w_ri + w_ir;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_p_re  = r_p_re;
    assign o_p_im  = r_p_im;

endmodule : cplx_mult

`default_nettype wire

// File: rtl/complex_mac_unit.sv
// ============================================================================
// Module      : complex_mac_unit
// Description : Streaming complex multiply-accumulate over FRAME_LEN samples
//               with a valid/ready frame-sum output and IDLE/RUN/STOP/ERR
//               control.
//               Build option COMPLEX_MAC_SAT_EN: accumulator saturates and
//               raises a sticky err instead of wrapping into ERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_mac_unit
    import cmn_state_pkg::*;
    import complex_mac_pkg::*;
#(
    parameter int DATA_W    = WIDTH,
    parameter int FRAME_LEN = DEPTH,
    parameter int ACC_W     = 2*DATA_W + $clog2(FRAME_LEN) + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  a_re,
    input  logic signed [DATA_W-1:0]  a_im,
    input  logic signed [DATA_W-1:0]  b_re,
    input  logic signed [DATA_W-1:0]  b_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   acc_re,
    output logic signed [ACC_W-1:0]   acc_im,
    output logic [1:0]                state,
    output logic                      err
);

`ifdef COMPLEX_MAC_SAT_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    localparam int c_PROD_W = 2*DATA_W + 1;
    localparam int c_CNT_W  = $clog2(FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0]      c_FRAME_CNT = c_CNT_W'(FRAME_LEN);
    localparam logic signed [ACC_W-1:0] c_ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                       r_state;
    state_t                       w_next_state;
    logic                         w_in_ready;
    logic                         w_out_valid;
    logic                         w_hs;
    logic [c_CNT_W-1:0]           r_cnt;
    logic                         r_err;
    logic signed [ACC_W-1:0]      r_acc_re;
    logic signed [ACC_W-1:0]      r_acc_im;

    logic                         r_p_valid;
    logic signed [c_PROD_W-1:0]   w_p_re;
    logic signed [c_PROD_W-1:0]   w_p_im;
    logic signed [ACC_W-1:0]      w_ext_re;
    logic signed [ACC_W-1:0]      w_ext_im;
    logic signed [ACC_W-1:0]      w_sum_re;
    logic signed [ACC_W-1:0]      w_sum_im;
    logic                         w_ovf_re;
    logic                         w_ovf_im;
    logic                         w_ovf;
    logic signed [ACC_W-1:0]      w_acc_nxt_re;
    logic signed [ACC_W-1:0]      w_acc_nxt_im;

    assign w_hs = in_valid && w_in_ready;

    cplx_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_hs),
        .i_a_re  (a_re),
        .i_a_im  (a_im),
        .i_b_re  (b_re),
        .i_b_im  (b_im),
        .o_valid (r_p_valid),
        .o_p_re  (w_p_re),
        .o_p_im  (w_p_im)
    );

    // Size cast sign-extends (or truncates when ACC_W is forced narrow)
    assign w_ext_re = ACC_W'(w_p_re);
    assign w_ext_im = ACC_W'(w_p_im);
    assign w_sum_re = r_acc_re + w_ext_re;
    assign w_sum_im = r_acc_im + w_ext_im;
    assign w_ovf_re = add_ovf(r_acc_re[ACC_W-1], w_ext_re[ACC_W-1], w_sum_re[ACC_W-1]);
    assign w_ovf_im = add_ovf(r_acc_im[ACC_W-1], w_ext_im[ACC_W-1], w_sum_im[ACC_W-1]);
    assign w_ovf    = w_ovf_re || w_ovf_im;

    // On overflow clamp toward the side the accumulator was already on
    assign w_acc_nxt_re = (c_SAT_EN && w_ovf_re)
                        ? (r_acc_re[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX) : w_sum_re;
    assign w_acc_nxt_im = (c_SAT_EN && w_ovf_im)
                        ? (r_acc_im[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX) : w_sum_im;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!clear && start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_in_ready = (r_cnt < c_FRAME_CNT);
                if ((r_cnt == c_FRAME_CNT) && !r_p_valid) begin
                    w_next_state = STOP;
                end
                if (!c_SAT_EN && r_p_valid && w_ovf) begin
                    w_next_state = ERR;
                end
            end
            STOP: begin
                w_out_valid = 1'b1;
                if (clear || out_ready) begin
                    w_next_state = IDLE;
                end
            end
            ERR: begin
                if (clear) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Sample counter, accumulator and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else begin
            if (r_state == IDLE && start && !clear) begin
                r_cnt    <= '0;
                r_err    <= 1'b0;
                r_acc_re <= '0;
                r_acc_im <= '0;
            end else if (r_state == RUN) begin
                if (w_hs) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_p_valid) begin
                    r_acc_re <= w_acc_nxt_re;
                    r_acc_im <= w_acc_nxt_im;
                    if (w_ovf) begin
                        r_err <= 1'b1;
                    end
                end
            end else if (clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign acc_re    = r_acc_re;
    assign acc_im    = r_acc_im;
    assign state     = r_state;
    assign err       = r_err;

endmodule : complex_mac_unit

`default_nettype wire
